mem_wb_elastic_stage: RTL and testbench
=======================================

// Module: mem_wb_elastic_stage
// PURPOSE
//  Parametrised, elastic MEM->WB pipeline stage. It replaces the fixed always-load MEM/WB register.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from WB never drops data.
//  in_ready is driven from a register, so there is no combinational ready path.
//  Adds a synchronous flush and a saturating stall-cycle counter. Sits between the data-memory stage and register write-back.
// PARAMETERS
//  DATA_W  32  width of ALU result and memory read data
//  REG_W    5  destination register index width
//  WB_W     2  write-back control field width
//  CNT_W   16  stall counter width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  flush       in   1       synchronous squash of all buffered entries
//  in_valid    in   1       upstream entry valid
//  in_ready    out  1       stage can accept an entry this cycle
//  in_result   in   DATA_W  ALU result
//  in_rdata    in   DATA_W  memory read data
//  in_rd       in   REG_W   destination register
//  in_wb       in   WB_W    write-back control
//  out_valid   out  1       entry presented to WB
//  out_ready   in   1       WB consumes entry this cycle
//  out_result  out  DATA_W  head entry result
//  out_rdata   out  DATA_W  head entry read data
//  out_rd      out  REG_W   head entry destination
//  out_wb      out  WB_W    head entry write-back control
//  occupancy   out  2       entries held (0..2)
//  stall_cnt   out  CNT_W   cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Handshake terms:
//  - Reset (async): all outputs 0 except in_ready=1; state EMPTY.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled at the rising edge.
//  - Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N when the buffer was EMPTY.
//  States (occupancy): EMPTY(0), ONE(1, head only), TWO(2, head + skid).
//  - EMPTY: accept -> ONE, load head.
//  - ONE:   accept & pop -> ONE, head <= input.
//           accept only -> TWO, skid <= input.
//           pop only -> EMPTY.
//           neither -> ONE.
//  - TWO:   pop -> ONE, head <= skid. No accept is possible in TWO.
//  - in_ready = (state != TWO). It is registered state, not a function of out_ready.
//  Ordering and payload:
//  - Entries leave strictly in acceptance order. No entry is duplicated or lost.
//  - Payload is held stable while out_valid=1 and out_ready=0.
//  - out_* payload is 0 whenever out_valid=0, including after a pop to EMPTY and after a flush.
//  Flush:
//  - flush=1 at edge -> state EMPTY, payload zeroed, in_ready=1.
//  - Flush has priority over a same-cycle accept or pop; the input on the flush cycle is dropped.
//  stall_cnt:
//  - Increments on each edge where out_valid & !out_ready.
//  - Saturates at 2^CNT_W-1. It is unaffected by flush and cleared only by rst.
//  Reset mid-operation: everything returns to the reset values immediately; buffered entries are discarded.
// TESTING
//  - Reset, then in_valid=1 with result=0x11 and out_ready=1 -> next cycle out_valid=1, out_result=0x11, occupancy=1.
//  - Streaming A,B,C with out_ready=1 every cycle -> A,B,C appear on consecutive cycles; in_ready stays 1.
//  - Hold out_ready=0, send A,B -> occupancy=2, in_ready=0, out shows A; stall_cnt climbs by 1 per cycle.
//  - From the previous case, raise out_ready -> out shows A, then B, then out_valid=0.
//  - Occupancy 2 plus flush=1 with in_valid=1 (D) -> next cycle out_valid=0, occupancy=0, in_ready=1; D is never output.
//  - CNT_W=4 with out_ready=0 for 20 cycles -> stall_cnt=15 and holds; assert rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_wb_elastic_stage_if.sv
// mem_wb_elastic_stage_if: valid/ready MEM->WB entry channel carrying result, read data, rd and wb control
interface mem_wb_elastic_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rdata;
    logic [REG_W-1:0]  rd;
    logic [WB_W-1:0]   wb;
    modport master (output valid, result, rdata, rd, wb, input ready);
    modport slave  (input valid, result, rdata, rd, wb, output ready);
endinterface

// File: rtl/mem_wb_elastic_stage.sv
// mem_wb_elastic_stage: elastic MEM->WB stage with 2-entry skid buffer, flush and saturating stall counter
module mem_wb_elastic_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    mem_wb_elastic_stage_if.slave  i_up,
    mem_wb_elastic_stage_if.master o_dn,
    output logic [1:0]         o_occupancy,
    output logic [CNT_W-1:0]   o_stall_cnt
);
    localparam int PW = 2 * DATA_W + REG_W + WB_W;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [PW-1:0]    r_head, r_skid, w_head_nx, w_skid_nx, w_in;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall;
    logic             w_acc, w_pop;
    assign w_in  = {i_up.result, i_up.rdata, i_up.rd, i_up.wb};
    assign w_acc = i_up.valid & r_in_ready;
    assign w_pop = (r_state != EMPTY) & o_dn.ready;
    always_comb begin
        w_next    = r_state;
        w_head_nx = r_head;
        w_skid_nx = r_skid;
        case (r_state)
            EMPTY: if (w_acc) begin
                w_next    = ONE;
                w_head_nx = w_in;
            end
            ONE: if (w_acc && w_pop) begin
                w_head_nx = w_in;
            end else if (w_acc) begin
                w_next    = TWO;
                w_skid_nx = w_in;
            end else if (w_pop) begin
                w_next    = EMPTY;
                w_head_nx = '0;
            end
            TWO: if (w_pop) begin
                w_next    = ONE;
                w_head_nx = r_skid;
                w_skid_nx = '0;
            end
            default: w_next = EMPTY;
        endcase
        if (i_flush) begin
            w_next    = EMPTY;
            w_head_nx = '0;
            w_skid_nx = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_head     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_head     <= w_head_nx;
            r_skid     <= w_skid_nx;
            r_in_ready <= (w_next != TWO);
        end
    end
    // counts every held-back cycle regardless of flush, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall <= '0;
        else if ((r_state != EMPTY) && !o_dn.ready && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + 1'b1;
    end
    assign i_up.ready  = r_in_ready;
    assign o_dn.valid  = (r_state != EMPTY);
    assign {o_dn.result, o_dn.rdata, o_dn.rd, o_dn.wb} = r_head;
    assign o_occupancy = r_state;
    assign o_stall_cnt = r_stall;
endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// tb_mem_wb_elastic_stage: directed self-checking bench for the elastic MEM->WB stage (CNT_W=4)
module tb_mem_wb_elastic_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;
    int         errors = 0;
    int         checks = 0;
    mem_wb_elastic_stage_if #(.DATA_W(32), .REG_W(5), .WB_W(2)) up ();
    mem_wb_elastic_stage_if #(.DATA_W(32), .REG_W(5), .WB_W(2)) dn ();
    mem_wb_elastic_stage #(.DATA_W(32), .REG_W(5), .WB_W(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_up(up), .o_dn(dn),
        .o_occupancy(occupancy), .o_stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] res);
        up.valid  = v;
        up.result = res;
        up.rdata  = res + 32'h11;
        up.rd     = res[4:0];
        up.wb     = res[1:0];
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [31:0] res, input logic [1:0] occ);
        chk({tag, "_valid"}, dn.valid, v);
        chk({tag, "_result"}, dn.result, res);
        chk({tag, "_rdata"}, dn.rdata, v ? res + 32'h11 : 32'h0);
        chk({tag, "_rd"}, dn.rd, v ? res[4:0] : 5'h0);
        chk({tag, "_occ"}, occupancy, occ);
    endtask
    initial begin
        drive(1'b0, 32'h0);
        dn.ready = 1'b0;
        #12;
        chk_out("reset", 1'b0, 32'h0, 2'd0);
        chk("reset_in_ready", up.ready, 1'b1);
        chk("reset_stall", stall_cnt, 4'd0);
        chk("reset_wb", dn.wb, 2'd0);
        rst = 1'b0;
        // single entry, one-cycle latency
        cyc();
        drive(1'b1, 32'h11);
        dn.ready = 1'b1;
        cyc();
        chk_out("first", 1'b1, 32'h11, 2'd1);
        chk("first_wb", dn.wb, 2'd1);
        chk("first_in_ready", up.ready, 1'b1);
        drive(1'b0, 32'h0);
        cyc();
        chk_out("first_drain", 1'b0, 32'h0, 2'd0);
        // streaming A,B,C
        drive(1'b1, 32'h0A);
        cyc();
        chk_out("stream_a", 1'b1, 32'h0A, 2'd1);
        drive(1'b1, 32'h0B);
        cyc();
        chk_out("stream_b", 1'b1, 32'h0B, 2'd1);
        chk("stream_b_ready", up.ready, 1'b1);
        drive(1'b1, 32'h0C);
        cyc();
        chk_out("stream_c", 1'b1, 32'h0C, 2'd1);
        chk("stream_c_ready", up.ready, 1'b1);
        drive(1'b0, 32'h0);
        cyc();
        chk_out("stream_end", 1'b0, 32'h0, 2'd0);
        chk("stream_stall", stall_cnt, 4'd0);
        // back-pressure fills the skid
        dn.ready = 1'b0;
        drive(1'b1, 32'hA1);
        cyc();
        chk_out("bp_a", 1'b1, 32'hA1, 2'd1);
        chk("bp_a_stall", stall_cnt, 4'd0);
        drive(1'b1, 32'hB2);
        cyc();
        chk_out("bp_full", 1'b1, 32'hA1, 2'd2);
        chk("bp_full_ready", up.ready, 1'b0);
        chk("bp_stall1", stall_cnt, 4'd1);
        drive(1'b1, 32'hEE);
        cyc();
        chk_out("bp_hold1", 1'b1, 32'hA1, 2'd2);
        chk("bp_stall2", stall_cnt, 4'd2);
        cyc();
        chk_out("bp_hold2", 1'b1, 32'hA1, 2'd2);
        chk("bp_stall3", stall_cnt, 4'd3);
        // release back-pressure: A was held, then B, then empty
        drive(1'b0, 32'h0);
        dn.ready = 1'b1;
        cyc();
        chk_out("drain_b", 1'b1, 32'hB2, 2'd1);
        chk("drain_b_ready", up.ready, 1'b1);
        chk("drain_stall", stall_cnt, 4'd3);
        cyc();
        chk_out("drain_empty", 1'b0, 32'h0, 2'd0);
        // flush while full, with a same-cycle input that must be dropped
        dn.ready = 1'b0;
        drive(1'b1, 32'h01);
        cyc();
        drive(1'b1, 32'h02);
        cyc();
        chk_out("pre_flush", 1'b1, 32'h01, 2'd2);
        chk("pre_flush_stall", stall_cnt, 4'd4);
        drive(1'b1, 32'h0D);
        flush = 1'b1;
        cyc();
        chk_out("flush", 1'b0, 32'h0, 2'd0);
        chk("flush_ready", up.ready, 1'b1);
        chk("flush_stall", stall_cnt, 4'd5);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        dn.ready = 1'b1;
        cyc();
        chk_out("post_flush", 1'b0, 32'h0, 2'd0);
        // saturation of the 4-bit stall counter
        dn.ready = 1'b0;
        drive(1'b1, 32'h33);
        cyc();
        drive(1'b0, 32'h0);
        chk("sat_start", stall_cnt, 4'd5);
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_15", stall_cnt, 4'd15);
        cyc();
        chk("sat_hold", stall_cnt, 4'd15);
        chk_out("sat_entry", 1'b1, 32'h33, 2'd1);
        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 2'd0);
        chk("async_rst_stall", stall_cnt, 4'd0);
        chk("async_rst_ready", up.ready, 1'b1);
        #10 rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
